// File: rtl/shift_sequencer.sv
// shift_sequencer: drives one load-and-shift transaction on an external
// shift_register. A word is accepted through START/READY, loaded with a
// single LOAD pulse, shifted out with SIZE strobes spaced DIVISOR+1 cycles
// apart (HOLD pauses, ABORT cancels), then PO is captured and DONE pulses.
module shift_sequencer #(
  parameter int SIZE      = 9,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [SIZE-1:0]      i_din,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic                 i_hold,
  input  logic                 i_abort,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_sr_load,
  output logic                 o_sr_se,
  output logic [SIZE-1:0]      o_sr_pi,
  input  logic [SIZE-1:0]      i_sr_po,
  output logic [SIZE-1:0]      o_rx_data,
  output logic                 o_done
);

  localparam int BW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_CAPTURE} state_t;

  state_t                 r_state;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_sr_load;
  logic                   r_done;
  logic [SIZE-1:0]        r_sr_pi;
  logic [SIZE-1:0]        r_rx_data;
  logic [DIV_WIDTH-1:0]   r_div_reg;
  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic [BW-1:0]          r_bit_cnt;

  logic                   w_tick;
  logic                   w_strobe;
  logic                   w_last_bit;

  // The divider clears at equality, so D = all-ones never wraps the counter.
  assign w_tick     = (r_div_cnt == r_div_reg);
  // HOLD must suppress the strobe in the very cycle it is raised, so the
  // shift enable is decoded from registered state plus the live HOLD input.
  assign w_strobe   = (r_state == S_SHIFT) && !i_hold && w_tick;
  assign w_last_bit = (r_bit_cnt == BW'(SIZE - 1));

  assign o_ready   = r_ready;
  assign o_busy    = r_busy;
  assign o_sr_load = r_sr_load;
  assign o_sr_se   = w_strobe;
  assign o_sr_pi   = r_sr_pi;
  assign o_rx_data = r_rx_data;
  assign o_done    = r_done;

  // Transaction FSM with its counters and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_sr_load <= 1'b0;
      r_done    <= 1'b0;
      r_sr_pi   <= '0;
      r_rx_data <= '0;
      r_div_reg <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_sr_load <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ABORT has no meaning here; a same-cycle START still goes through.
          if (i_start) begin
            r_sr_pi   <= i_din;
            r_div_reg <= i_divisor;
            r_sr_load <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          if (i_abort) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // ABORT outranks HOLD; HOLD simply freezes both counters.
          if (i_abort) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (!i_hold) begin
            if (w_tick) begin
              r_div_cnt <= '0;
              r_bit_cnt <= r_bit_cnt + BW'(1);
              if (w_last_bit) r_state <= S_CAPTURE;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
            end
          end
        end
        S_CAPTURE: begin
          // PO already holds the result of the final strobe; abort skips it.
          if (!i_abort) begin
            r_rx_data <= i_sr_po;
            r_done    <= 1'b1;
          end
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift register on
// the SR_* pins. The register shifts in the bits of 'pat' (MSB first), so
// after exactly SIZE strobes PO equals 'pat' and RX_DATA must match it.
// Cycle 0 is the cycle START is accepted; strobe k lands in 2+D+(k-1)(D+1).
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, hold, abort;
  logic [8:0] din;
  logic [7:0] divisor;
  logic       ready, busy, sr_load, sr_se, done;
  logic [8:0] sr_pi, rx;
  logic [8:0] sr_po = '0;
  logic [8:0] pat   = '0;
  int         shcnt = 0;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  int se_q[$];
  int ld_n, ld_c, dn_n, dn_c, nrdy;
  logic       rdy0;
  logic [8:0] rx0, rxn, pin;

  shift_sequencer #(.SIZE(9), .DIV_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din),
    .i_divisor(divisor), .i_hold(hold), .i_abort(abort),
    .o_ready(ready), .o_busy(busy), .o_sr_load(sr_load), .o_sr_se(sr_se),
    .o_sr_pi(sr_pi), .i_sr_po(sr_po), .o_rx_data(rx), .o_done(done)
  );

  always #5 clk = ~clk;

  // Behavioural shift register: LOAD from PI, else shift in next pat bit.
  always @(posedge clk) begin
    if (sr_load) begin
      sr_po <= sr_pi;
      shcnt <= 0;
    end else if (sr_se) begin
      sr_po <= {sr_po[7:0], pat[8 - (shcnt % 9)]};
      shcnt <= shcnt + 1;
    end
  end

  // LOAD and SE must never coincide.
  always @(negedge clk) if (sr_load && sr_se) overlap++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction starting now (just after a rising edge), observed for
  // cycles 0..n. HOLD is high in cycles hs..hs+hl-1, ABORT in cycle ab.
  task automatic run(input logic [8:0] d_in, input logic [7:0] dv,
                     input int hs, input int hl, input int ab, input int n);
    se_q.delete();
    ld_n = 0; ld_c = -1; dn_n = 0; dn_c = -1; nrdy = 0;
    start = 1'b1; din = d_in; divisor = dv; hold = 1'b0; abort = 1'b0;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        start = 1'b0;
        din   = ~d_in;
        hold  = (c >= hs) && (c < hs + hl);
        abort = (c == ab);
      end
      @(negedge clk);
      if (c == 0) begin rdy0 = ready; rx0 = rx; end
      if (c == n) rxn = rx;
      if (sr_se) se_q.push_back(c);
      if (sr_load) begin ld_n++; ld_c = c; end
      if (done) begin dn_n++; dn_c = c; end
      if (c > 0 && !ready) nrdy++;
      @(posedge clk); #1;
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; din = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_load",  32'(sr_load), 32'd0);
    chk("rst_se",    32'(sr_se), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_rx",    32'(rx),    32'd0);
    chk("rst_pi",    32'(sr_pi), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // D=0: load in 1, strobes 2..10, capture 11, DONE 12.
    pat = 9'h1FF;
    run(9'h1A5, 8'd0, 999, 0, -1, 12);
    chk("t1_se_cnt",  32'(se_q.size()), 32'd9);
    chk("t1_se_first", 32'(se_q[0]), 32'd2);
    chk("t1_se_last",  32'(se_q[8]), 32'd10);
    chk("t1_ld_cnt",  32'(ld_n), 32'd1);
    chk("t1_ld_cyc",  32'(ld_c), 32'd1);
    chk("t1_dn_cnt",  32'(dn_n), 32'd1);
    chk("t1_dn_cyc",  32'(dn_c), 32'd12);
    chk("t1_notready", 32'(nrdy), 32'd11);
    chk("t1_rx",      32'(rxn), 32'h1FF);
    chk("t1_pi",      32'(sr_pi), 32'h1A5);

    // D=3: strobes 5,9,...,37, capture 38, DONE 39.
    pat = 9'h0C3;
    run(9'h0F0, 8'd3, 999, 0, -1, 39);
    chk("t2_se_cnt",  32'(se_q.size()), 32'd9);
    chk("t2_se_first", 32'(se_q[0]), 32'd5);
    chk("t2_se_2nd",  32'(se_q[1]), 32'd9);
    chk("t2_se_last",  32'(se_q[8]), 32'd37);
    chk("t2_dn_cyc",  32'(dn_c), 32'd39);
    chk("t2_notready", 32'(nrdy), 32'd38);
    chk("t2_rx",      32'(rxn), 32'h0C3);

    // D=1 with HOLD over cycles 7..10 (the 3rd strobe slot): strobes
    // 3,5, then 11,13,...,23; DONE moves from 21 to 25.
    pat = 9'h12D;
    run(9'h055, 8'd1, 7, 4, -1, 25);
    chk("t3_se_cnt",  32'(se_q.size()), 32'd9);
    chk("t3_se_1",    32'(se_q[0]), 32'd3);
    chk("t3_se_2",    32'(se_q[1]), 32'd5);
    chk("t3_se_3",    32'(se_q[2]), 32'd11);
    chk("t3_se_last", 32'(se_q[8]), 32'd23);
    chk("t3_dn_cyc",  32'(dn_c), 32'd25);
    chk("t3_rx",      32'(rxn), 32'h12D);

    // D=0, ABORT in the 5th strobe cycle (6): five strobes, no DONE.
    pat = 9'h0F0;
    run(9'h1C1, 8'd0, 999, 0, 6, 6);
    chk("t4_se_cnt",  32'(se_q.size()), 32'd5);
    chk("t4_se_last", 32'(se_q[4]), 32'd6);
    chk("t4_dn_cnt",  32'(dn_n), 32'd0);
    chk("t4_rx_keep", 32'(rxn), 32'h12D);

    // Immediately afterwards: READY already high, counters start fresh.
    pat = 9'h0B6;
    run(9'h033, 8'd0, 999, 0, -1, 12);
    chk("t5_ready0",  32'(rdy0), 32'd1);
    chk("t5_rx_keep", 32'(rx0), 32'h12D);
    chk("t5_se_cnt",  32'(se_q.size()), 32'd9);
    chk("t5_se_first", 32'(se_q[0]), 32'd2);
    chk("t5_ld_cyc",  32'(ld_c), 32'd1);
    chk("t5_dn_cyc",  32'(dn_c), 32'd12);
    chk("t5_rx",      32'(rxn), 32'h0B6);

    // Maximum divisor D=255: strobes 257..2305 every 256, DONE 2307.
    pat = 9'h1E1;
    run(9'h000, 8'd255, 999, 0, -1, 2307);
    chk("t6_se_cnt",  32'(se_q.size()), 32'd9);
    chk("t6_se_first", 32'(se_q[0]), 32'd257);
    chk("t6_se_2nd",  32'(se_q[1]), 32'd513);
    chk("t6_se_last", 32'(se_q[8]), 32'd2305);
    chk("t6_dn_cyc",  32'(dn_c), 32'd2307);
    chk("t6_rx",      32'(rxn), 32'h1E1);

    // START held high, DIN toggling every cycle: accepted in 0 (155) and
    // in 12 (0AA), loads in 1 and 13; busy-time DIN values are ignored.
    pat = 9'h0AB;
    ld_n = 0; ld_c = -1; dn_c = -1;
    for (int c = 0; c <= 14; c++) begin
      start = 1'b1;
      divisor = 8'd0;
      din = (c == 0) ? 9'h155 : ((c % 2 == 1) ? 9'h155 : 9'h0AA);
      @(negedge clk);
      if (sr_load) begin
        if (ld_n == 0) ld_c = c; else chk("t7_ld_gap", 32'(c - ld_c), 32'd12);
        ld_n++;
      end
      if (done) dn_c = c;
      if (c == 6)  chk("t7_pi_c6",  32'(sr_pi), 32'h155);
      if (c == 12) begin
        chk("t7_pi_c12", 32'(sr_pi), 32'h155);
        chk("t7_rx_c12", 32'(rx), 32'h0AB);
      end
      if (c == 13) chk("t7_pi_c13", 32'(sr_pi), 32'h0AA);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("t7_ld_cnt",  32'(ld_n), 32'd2);
    chk("t7_ld_first", 32'(ld_c), 32'd1);
    chk("t7_dn_cyc",  32'(dn_c), 32'd12);

    // Second transaction is mid-SHIFT: reset with ABORT and HOLD also high.
    rst = 1'b1; abort = 1'b1; hold = 1'b1;
    @(negedge clk);
    chk("t8_pre_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0; hold = 1'b0;
    @(negedge clk);
    chk("t8_ready", 32'(ready), 32'd1);
    chk("t8_busy",  32'(busy),  32'd0);
    chk("t8_load",  32'(sr_load), 32'd0);
    chk("t8_se",    32'(sr_se), 32'd0);
    chk("t8_done",  32'(done),  32'd0);
    chk("t8_rx",    32'(rx),    32'd0);
    chk("t8_pi",    32'(sr_pi), 32'd0);
    dn_n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || sr_se) dn_n++;
    end
    chk("t8_quiet", 32'(dn_n), 32'd0);

    chk("load_se_overlap", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
